// File: rtl/register_file_8x.sv
// Eight-entry register file: two combinational read ports, one synchronous write port, r0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file_8x #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [15:0]       write_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [15:0]       count_q;
  logic [15:0]       count_d;
  logic              wr_en;
  logic [DATA_W-1:0] stored_1;
  logic [DATA_W-1:0] stored_2;

  // An X or 0 on RegWrite falls to the no-write branch.
  assign wr_en = (RegWrite == 1'b1) && (write_reg != '0);

  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (wr_en) begin
      regs_d[write_reg] = write_data;
      count_d           = count_q + 16'd1;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  assign stored_1 = (read_reg_1 == '0) ? '0 : regs_q[read_reg_1];
  assign stored_2 = (read_reg_2 == '0) ? '0 : regs_q[read_reg_2];

`ifdef REGFILE_BYPASS_EN
  // wr_en already excludes r0; rst_n gating keeps forwarding off during reset.
  assign read_data_1 = (rst_n && wr_en && (read_reg_1 == write_reg)) ? write_data : stored_1;
  assign read_data_2 = (rst_n && wr_en && (read_reg_2 == write_reg)) ? write_data : stored_2;
`else
  assign read_data_1 = stored_1;
  assign read_data_2 = stored_2;
`endif

  assign write_count = count_q;

endmodule

// File: doc/register_file_8x.md
# register_file_8x

Eight-entry general-purpose register file for the single-cycle datapath; the write-register mux drives its write-address port. Two combinational read ports feed the ALU operand path. One synchronous write port receives the write-back result. Register 0 is hardwired to zero. An optional compile-time bypass forwards same-cycle write data to the read ports.

## Interface
- `DATA_W`, default 32: register and data width in bits.
- `ADDR_W`, default 3: register address width. Depth is 2^ADDR_W = 8.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low. Clears every register to 0.
- `read_reg_1` input ADDR_W: read port 1 address (rs field).
- `read_reg_2` input ADDR_W: read port 2 address (rt field).
- `write_reg` input ADDR_W: write address, from the RegDst mux output.
- `write_data` input DATA_W: write-back value.
- `RegWrite` input 1: write enable, active-high.
- `read_data_1` output DATA_W: contents of `read_reg_1`.
- `read_data_2` output DATA_W: contents of `read_reg_2`.
- `write_count` output 16: number of committed writes since reset. Debug and verification aid.

## Operation
- Storage is an array of 8 words of DATA_W bits. Entry 0 has no storage and always reads as 0.
- Write: on the rising `clk` edge, if `RegWrite`=1 and `write_reg`≠0, the selected entry takes `write_data`, and `write_count` increments by 1.
- Writes to entry 0 are discarded and do not increment `write_count`.
- `write_count` wraps from 16'hFFFF to 16'h0000 with no flag.
- Read: each port is purely combinational, `read_data_n` = array[`read_reg_n`]. A read address of 0 returns 0.
- Both read ports may address the same entry simultaneously. Each port returns the same value independently.
- Unknown or X on `RegWrite` must not corrupt storage. The bench drives only 0 or 1. RTL treats any non-1 value as no write.
- Reset: while `rst_n`=0, all entries are 0, `write_count`=0, and both read outputs read 0 for any address. The clock edge is ignored while reset is asserted.
- Reset mid-operation: assertion clears state immediately, with no clock needed. The first write after deassertion is accepted on the first rising edge where `rst_n`=1.

## Timing
- Read latency: 0 cycles, combinational from address to data.
- Write latency: 1 cycle. Data written at edge N is visible on the read ports after edge N.
- Read-during-write, same address, bypass compiled out: the read returns the old value until the edge, then the new value.
- Reset values of outputs: `read_data_1` = `read_data_2` = 0 and `write_count` = 0.
- No handshake. A write is accepted every cycle that `RegWrite`=1. Back-to-back writes to the same entry leave the last value.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: when `RegWrite`=1, `write_reg`≠0, and `read_reg_n`==`write_reg`, `read_data_n` = `write_data` combinationally in the same cycle. This applies per port independently. It never applies to entry 0, and it is inactive during reset.
- Not defined: no forwarding. Reads always return the array contents.
- Write, storage and `write_count` behaviour are identical in both builds.

## Test plan
- Reset check: assert `rst_n`=0 mid-run after writing r3=32'hDEADBEEF -> `read_data_1`(r3)=0 immediately and `write_count`=0.
- Write/read all entries: write r1..r7 = 32'h11111111×n with `RegWrite`=1 -> each reads back correctly on both ports, r0 reads 0, and `write_count`=7.
- Register 0 protection: write r0=32'hFFFFFFFF -> r0 reads 0 and `write_count` is unchanged.
- Write enable gating: `RegWrite`=0 with `write_reg`=5 and `write_data`=32'h12345678 -> r5 keeps its previous value.
- Read-during-write on r4 (old value 32'hA, new value 32'hB), both read ports on r4:
  - Bypass build: 32'hB before the edge.
  - Non-bypass build: 32'hA before the edge, 32'hB after it.
- Counter wrap: force 65536 writes to r2 -> `write_count` returns to 0 and r2 holds the last value written.
